// File: rtl/dotp_job_controller.sv
// dotp_job_controller
//
// Job sequencer for the dot-product engine. It owns the address/write port
// of the shared 16x8 operand memory: it streams 16 host bytes into it
// (A at 0..7, B at 8..15), pulses the engine's start, hands the address
// port to the engine while it runs, watches for completion with a timeout,
// and hands the 8-bit result back to the host.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   soft_clr         synchronous abort of a load or a pending result
//                    (ignored while the engine is being started or is running)
//   in_valid/in_ready/in_data     host operand byte stream
//   res_valid/res_ready/res_data  result handshake; res_err marks a timeout
//   busy             high whenever the controller is not idle
//   job_count        completed jobs (timed-out ones included), wraps at 256
//   mem_addr/mem_wr/mem_wdata     operand memory port
//   eng_start        one-cycle start pulse to the engine
//   eng_mem_addr     engine address, routed to mem_addr while it runs
//   eng_mem_wr       engine write request, never forwarded
//   eng_done/eng_result           engine completion pulse and result

module dotp_job_controller #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_clr,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_err,
  input  logic       res_ready,
  output logic       busy,
  output logic [7:0] job_count,
  output logic [3:0] mem_addr,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  output logic       eng_start,
  input  logic [3:0] eng_mem_addr,
  input  logic       eng_mem_wr,
  input  logic       eng_done,
  input  logic [7:0] eng_result
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t           state;
  logic [3:0]       byte_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [3:0]       wr_addr;
  logic             wr_en;
  logic             accept;
  logic             timeout_hit;

  // The engine may request writes, but operands are read-only to it.
  logic unused_eng_mem_wr;
  assign unused_eng_mem_wr = eng_mem_wr;

  // in_ready is only ever high in IDLE/LOAD, so it alone qualifies a beat.
  // An abort in the same cycle takes priority over the beat.
  assign accept      = in_valid & in_ready & ~soft_clr;
  assign timeout_hit = (cyc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // While the engine runs it owns the address port; the registered write
  // path is masked so nothing reaches the memory on its behalf.
  assign mem_addr = (state == RUN) ? eng_mem_addr : wr_addr;
  assign mem_wr   = wr_en & (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= 4'd0;
      cyc_cnt   <= '0;
      wr_addr   <= 4'd0;
      wr_en     <= 1'b0;
      mem_wdata <= 8'd0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 8'd0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      job_count <= 8'd0;
      eng_start <= 1'b0;
    end else begin
      // Single-cycle strobes.
      wr_en     <= 1'b0;
      eng_start <= 1'b0;

      case (state)
        // ---- operand load: IDLE takes byte 0, LOAD takes bytes 1..15 ----
        IDLE, LOAD: begin
          if (soft_clr) begin
            state     <= IDLE;
            byte_cnt  <= 4'd0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end else begin
            // Also raises in_ready on the first cycle after reset.
            in_ready <= 1'b1;
            if (accept) begin
              wr_en     <= 1'b1;
              wr_addr   <= byte_cnt;
              mem_wdata <= in_data;
              byte_cnt  <= byte_cnt + 4'd1;
              busy      <= 1'b1;
              if (byte_cnt == 4'd15) begin
                // Last byte: stop accepting and start the engine while the
                // final write lands.
                state     <= START;
                in_ready  <= 1'b0;
                eng_start <= 1'b1;
              end else begin
                state <= LOAD;
              end
            end
          end
        end

        // ---- start cycle: byte 15 is written, engine sees eng_start ----
        START: begin
          state   <= RUN;
          cyc_cnt <= '0;
        end

        // ---- engine running: wait for done or time out ----
        RUN: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          if (eng_done) begin
            // Completion wins even on the timeout cycle.
            res_data  <= eng_result;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            job_count <= job_count + 8'd1;
            state     <= HOLD;
          end else if (timeout_hit) begin
            res_data  <= 8'd0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            job_count <= job_count + 8'd1;
            state     <= HOLD;
          end
        end

        // ---- result held until the host takes it ----
        HOLD: begin
          if (soft_clr) begin
            state     <= IDLE;
            byte_cnt  <= 4'd0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end else if (res_valid && res_ready) begin
            state     <= IDLE;
            byte_cnt  <= 4'd0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          byte_cnt <= 4'd0;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dotp_job_controller.sv
// Directed bench for dotp_job_controller. The engine is modelled by the
// bench: it follows the operand memory through the write port and returns
// the low 8 bits of sum(A[i]*B[i]) after a chosen latency (or never).

module tb_dotp_job_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       soft_clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_err;
  logic       res_ready = 1'b0;
  logic       busy;
  logic [7:0] job_count;
  logic [3:0] mem_addr;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic       eng_start;
  logic [3:0] eng_mem_addr = 4'd0;
  logic       eng_mem_wr = 1'b0;
  logic       eng_done = 1'b0;
  logic [7:0] eng_result = 8'd0;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [16];
  logic [3:0] log_addr [256];
  logic [7:0] log_data [256];
  int wr_cnt = 0;
  int starts = 0;
  int route_bad = 0;

  always #5 clk = ~clk;

  dotp_job_controller #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .soft_clr(soft_clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .res_ready(res_ready), .busy(busy), .job_count(job_count),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .eng_start(eng_start), .eng_mem_addr(eng_mem_addr),
    .eng_mem_wr(eng_mem_wr), .eng_done(eng_done), .eng_result(eng_result)
  );

  // Operand memory model plus a log of every write and start pulse.
  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_addr]          <= mem_wdata;
      log_addr[wr_cnt[7:0]]  <= mem_addr;
      log_data[wr_cnt[7:0]]  <= mem_wdata;
      wr_cnt                 <= wr_cnt + 1;
    end
    if (eng_start) starts <= starts + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"},  in_ready,  0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"},  res_data,  0);
    chk({tag, "_res_err"},   res_err,   0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_job_count"}, job_count, 0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_mem_wr"},    mem_wr,    0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
  endtask

  // Offer n beats starting at a negedge; optional random idle gaps.
  task automatic load_n(input logic [7:0] v [16], input int n, input bit gaps, input bit keep);
    int g;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          in_valid = 1'b0;
          in_data  = 8'hEE;
          @(negedge clk);
        end
      end
      chk("beat_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = v[k];
      @(negedge clk);
    end
    if (!keep) in_valid = 1'b0;
  endtask

  // Engine model; lat < 0 means it never finishes. ncyc = RUN cycles
  // before res_valid was seen (-1 if never within the budget).
  task automatic engine(input int lat, output int ncyc);
    logic [7:0] acc;
    @(negedge clk);
    acc = 8'd0;
    for (int i = 0; i < 8; i++) acc = acc + mem[i] * mem[i + 8];
    ncyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (res_valid) begin
        ncyc = i;
        break;
      end
      eng_mem_addr = 4'(i * 5 + 3);
      eng_mem_wr   = 1'b1;
      #1;
      if (mem_addr !== eng_mem_addr || mem_wr !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)
        route_bad++;
      eng_done   = (i == lat);
      eng_result = (i == lat) ? acc : 8'h5A;
      @(negedge clk);
      eng_done   = 1'b0;
      eng_mem_wr = 1'b0;
    end
  endtask

  task automatic run_job(input logic [7:0] v [16], input bit gaps, input bit keep,
                         input int lat, output int ncyc);
    int s0;
    s0 = starts;
    load_n(v, 16, gaps, keep);
    chk("start_in_ready", in_ready, 0);
    chk("start_pulse", eng_start, 1);
    chk("start_busy", busy, 1);
    chk("start_wr15", {mem_wr, mem_addr}, {1'b1, 4'hF});
    engine(lat, ncyc);
    chk("one_start", starts - s0, 1);
    chk("route_run", route_bad, 0);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("rel_valid", res_valid, 0);
    chk("rel_err", res_err, 0);
    chk("rel_busy", busy, 0);
    chk("rel_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [7:0] j1 [16];
    logic [7:0] jf [16];
    logic [7:0] jg [16];
    int nc;
    int w0;
    int quiet_bad;

    for (int k = 0; k < 16; k++) begin
      j1[k] = (k < 8) ? 8'(k + 1) : 8'd1;        // sum 36 = 0x24
      jf[k] = 8'hFF;                              // sum 0x7F008
      jg[k] = (k < 8) ? 8'd3 : 8'(k - 6);         // 3*(2+..+9) = 0x84
    end

    // Reset state
    #1 rst = 1'b1;
    #1 chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);

    // Job 1: in_valid held high throughout
    w0 = wr_cnt;
    run_job(j1, 1'b0, 1'b1, 41, nc);
    chk("j1_latency", nc, 42);
    chk("j1_valid", res_valid, 1);
    chk("j1_data", res_data, 8'h24);
    chk("j1_err", res_err, 0);
    chk("j1_count", job_count, 1);
    chk("j1_no_extra_beat", wr_cnt - w0, 16);
    in_valid = 1'b0;
    release_res();

    // Job 2: all 0xFF, result held 20 cycles
    run_job(jf, 1'b0, 1'b0, 10, nc);
    for (int c = 0; c < 20; c++) begin
      chk("j2_hold_valid", res_valid, 1);
      chk("j2_hold_data", res_data, 8'h08);
      @(negedge clk);
    end
    release_res();
    chk("j2_count", job_count, 2);

    // Job 3: random gaps, write order and data
    w0 = wr_cnt;
    run_job(jg, 1'b1, 1'b0, 20, nc);
    chk("j3_data", res_data, 8'h84);
    chk("j3_writes", wr_cnt - w0, 16);
    for (int k = 0; k < 16; k++) begin
      chk("j3_wr_addr", log_addr[8'(w0 + k)], k);
      chk("j3_wr_data", log_data[8'(w0 + k)], jg[k]);
    end
    chk("j3_count", job_count, 3);
    release_res();

    // Job 4: engine hangs -> timeout, then abort from HOLD
    run_job(j1, 1'b0, 1'b0, -1, nc);
    chk("to_latency", nc, 64);
    chk("to_valid", res_valid, 1);
    chk("to_err", res_err, 1);
    chk("to_data", res_data, 0);
    chk("to_count", job_count, 4);
    soft_clr = 1'b1;
    @(negedge clk);
    soft_clr = 1'b0;
    chk("hold_clr_valid", res_valid, 0);
    chk("hold_clr_err", res_err, 0);
    chk("hold_clr_busy", busy, 0);
    chk("hold_clr_count", job_count, 4);

    // Job 5: eng_done on the timeout cycle is not an error
    run_job(j1, 1'b0, 1'b0, 63, nc);
    chk("edge_latency", nc, 64);
    chk("edge_err", res_err, 0);
    chk("edge_data", res_data, 8'h24);
    chk("edge_count", job_count, 5);
    release_res();

    // Job 6: abort after 5 bytes, then a full load
    w0 = wr_cnt;
    load_n(j1, 5, 1'b0, 1'b0);
    chk("partial_busy", busy, 1);
    soft_clr = 1'b1;
    @(negedge clk);
    soft_clr = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_writes", wr_cnt - w0, 5);
    run_job(j1, 1'b0, 1'b0, 30, nc);
    chk("j6_data", res_data, 8'h24);
    chk("j6_count", job_count, 6);
    release_res();

    // Reset pulsed at RUN cycle 10
    load_n(j1, 16, 1'b0, 1'b0);
    @(negedge clk);
    repeat (10) @(negedge clk);
    eng_mem_addr = 4'd9;
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    quiet_bad = 0;
    for (int c = 0; c < 80; c++) begin
      eng_done = (c % 7 == 3);
      eng_result = 8'h77;
      @(negedge clk);
      if (res_valid !== 1'b0 || eng_start !== 1'b0 || busy !== 1'b0) quiet_bad++;
    end
    eng_done = 1'b0;
    chk("post_rst_quiet", quiet_bad, 0);
    chk("post_rst_count", job_count, 0);

    // 256 jobs: job_count wraps to 0
    for (int j = 0; j < 256; j++) begin
      run_job(j1, 1'b0, 1'b0, 0, nc);
      chk("wrap_job_data", res_data, 8'h24);
      if (j == 254) chk("wrap_255", job_count, 8'd255);
      release_res();
    end
    chk("wrap_zero", job_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dotp_job_controller.md
Name: dotp_job_controller

Overview:
- Job sequencer and memory-port owner for the dot-product engine.
- Accepts a 16-byte operand stream from the host over a valid/ready handshake and writes it into the shared 16x8 operand memory: bytes 0-7 are vector A at addresses 0-7, bytes 8-15 are vector B at addresses 8-15.
- Pulses the engine's start, hands the memory address port to the engine while it runs, and watches for completion with a timeout.
- Returns the 8-bit result to the host over a second valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 64, maximum RUN cycles without eng_done before the job is aborted with an error (the engine's nominal job length is about 42 cycles).
- CNT_W, 7, width of the RUN cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- soft_clr  in  1  synchronous abort of the current load or result; ignored in START and RUN
- in_valid  in  1  host operand byte valid
- in_data  in  8  host operand byte
- in_ready  out  1  controller can accept an operand byte
- res_valid  out  1  result available
- res_data  out  8  dot-product result (low 8 bits of the sum)
- res_err  out  1  qualifies res_valid: 1 means the job timed out
- res_ready  in  1  host accepts the result
- busy  out  1  high in every state except IDLE
- job_count  out  8  number of completed jobs, including timed-out ones
- mem_addr  out  4  operand memory address
- mem_wr  out  1  operand memory write enable
- mem_wdata  out  8  operand memory write data
- eng_start  out  1  one-cycle start pulse to the engine
- eng_mem_addr  in  4  engine's requested memory address
- eng_mem_wr  in  1  engine's write request (never forwarded)
- eng_done  in  1  engine completion pulse
- eng_result  in  8  engine result, valid while eng_done is high

Behaviour:
- Reset values: state=IDLE, byte counter=0, cycle counter=0; all outputs 0 (in_ready, res_valid, res_data, res_err, busy, job_count, mem_addr, mem_wr, mem_wdata, eng_start).
- States: IDLE, LOAD, START, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - An accepted beat (in_valid & in_ready) writes byte 0 and moves to LOAD.
- LOAD:
  - in_ready=1.
  - Accepted beat k (k=0..15) produces, on the next cycle, registered mem_wr=1, mem_addr=k, mem_wdata=byte. mem_wr is 0 in every other cycle.
  - Gaps in in_valid are allowed; the byte counter holds during gaps.
  - Accepting beat 15 moves to START, and in_ready drops in the same cycle the move takes effect.
- START:
  - One cycle with eng_start=1; the write of byte 15 completes in this cycle.
  - Next state RUN; cycle counter cleared.
- RUN:
  - mem_addr is driven combinationally from eng_mem_addr.
  - mem_wr is forced to 0 and eng_mem_wr is ignored.
  - in_ready=0; in_valid is ignored and no byte is consumed.
  - The cycle counter increments each cycle.
  - eng_done=1: capture eng_result into res_data, set res_err=0, res_valid=1, increment job_count, go to HOLD.
  - Counter reaches TIMEOUT_CYCLES-1 without eng_done: set res_data=0, res_err=1, res_valid=1, increment job_count, go to HOLD.
  - eng_done arriving on the timeout cycle wins; that job is not an error.
- HOLD:
  - res_valid, res_data and res_err are held stable until res_valid & res_ready.
  - On that handshake: res_valid=0, res_err=0, state IDLE.
  - in_ready=0 in HOLD.
- soft_clr in IDLE, LOAD or HOLD:
  - next state IDLE, byte counter=0, res_valid=0, res_err=0, no job_count change.
  - Memory contents already written are left as they are.
- job_count wraps from 255 to 0.
- rst asserted mid-RUN or at any other point: everything returns to reset values immediately, and eng_start stays 0 until a new load completes.

Test Plan:
- Load A=1,2,...,8 and B=1 x8 with in_valid held high → in_ready low after beat 16; exactly one eng_start pulse; res_valid=1, res_data=0x24, res_err=0, job_count=1.
- A=0xFF x8, B=0xFF x8 (sum 0x7F008), res_ready held low 20 cycles → res_data=0x08 stable throughout HOLD; clears one cycle after res_ready rises.
- Random in_valid gaps during load → memory writes exactly addresses 0..15 in order with the correct data; no write while in_valid is low; a beat offered during RUN is not consumed.
- Engine stub never asserts eng_done → res_valid after TIMEOUT_CYCLES=64 RUN cycles, res_err=1, res_data=0x00; eng_mem_wr=1 from the stub never reaches mem_wr.
- soft_clr after 5 bytes, then a full 16-byte load of job 1's vectors → res_data=0x24 and job_count increments by one only.
- rst pulsed at RUN cycle 10 → all outputs 0 asynchronously; no res_valid until a new full load completes; run 256 jobs and check job_count wraps to 0.
